seq_run_ctrl: RTL
=================

SEQ_RUN_CTRL -- requirements
Module: seq_run_ctrl

Interface
REQ-001 Parameter: PASS_W, default 4, width of the pass-count request and status.
REQ-002 clk  in  1  clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  level, sampled each cycle; request a run; honoured only in IDLE.
REQ-005 stop  in  1  abort the current run; honoured in RUN and PAUSE.
REQ-006 hold  in  1  freeze the sequence while high during a run.
REQ-007 num_passes  in  PASS_W  full sequence passes per run, sampled when start is accepted; 0 means run until stop.
REQ-008 q  out  4  current sequence value.
REQ-009 pass_cnt  out  PASS_W  completed passes in the current run.
REQ-010 busy  out  1  high whenever state is not IDLE.
REQ-011 wrap  out  1  one-cycle pulse in the cycle q returns from 14 to 0.
REQ-012 done  out  1  one-cycle pulse when the requested passes complete.
REQ-013 err  out  1  sticky illegal-value flag; cleared by an accepted start.

Function
REQ-014 Sequence SHALL be 0,1,3,7,9,11,13,14, then 0, cyclic; one step per cycle in RUN with hold low.
REQ-015 FSM SHALL have exactly four states: IDLE, RUN, PAUSE, DONE.
REQ-016 In IDLE with start=1 and stop=0, the block SHALL latch num_passes, clear pass_cnt, clear err, set q=0 and enter RUN next cycle.
REQ-017 In IDLE, start=1 with stop=1 SHALL be ignored; stop wins.
REQ-018 start in RUN, PAUSE or DONE SHALL be ignored with no effect on q or pass_cnt.
REQ-019 In RUN with hold=1, q SHALL freeze and the next state SHALL be PAUSE; in PAUSE with hold=0, the next state SHALL be RUN and stepping SHALL resume from the frozen value.
REQ-020 On each 14->0 step, wrap SHALL pulse and pass_cnt SHALL increment, saturating at all-ones.
REQ-021 If the latched num_passes is nonzero and the incremented pass_cnt equals it, the FSM SHALL enter DONE in the same cycle q becomes 0.
REQ-022 DONE SHALL last exactly one cycle with done=1, then go to IDLE; q=0 and pass_cnt SHALL hold until the next start.
REQ-023 stop in RUN or PAUSE SHALL go to IDLE next cycle with q=0, no done pulse, and pass_cnt retained; stop takes priority over hold and over completion in the same cycle.
REQ-024 If q holds a value outside the legal set, the next q SHALL be 0 and err SHALL set; the run continues.
REQ-025 Latency: start accepted at edge T gives busy=1 and q=0 at T+1, and q=1 at T+2.

Reset
REQ-026 Asserting rst_n low SHALL immediately force IDLE, q=0, pass_cnt=0, busy=0, wrap=0, done=0, err=0, including during an active run.
REQ-027 After rst_n deasserts, the block SHALL remain in IDLE until start is sampled.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding and the legal-sequence constants (first=0, last=14).
REQ-029 Next-value logic SHALL sit in a single sub-module, seq_step: inputs q and en; outputs next q and an illegal flag. The FSM, pass counting and flags stay in seq_run_ctrl.
REQ-030 All outputs SHALL be registered.

Verification
REQ-031 Test: num_passes=1, start at T -> q=0,1,3,7,9,11,13,14 on T+1..T+8; at T+9 q=0, wrap=1, pass_cnt=1, done=1; busy=0 at T+10.
REQ-032 Test: num_passes=3 -> exactly 3 wrap pulses and 1 done pulse; final pass_cnt=3.
REQ-033 Test: num_passes=0 -> runs more than 20 passes with no done pulse; stop -> IDLE next cycle, q=0, done never pulsed.
REQ-034 Test: hold=1 for 5 cycles while q=7 -> q stays 7 and state is PAUSE; after hold drops, next q=9.
REQ-035 Test: start and stop together in IDLE -> stays IDLE; start while busy -> no effect on q or pass_cnt.
REQ-036 Test: rst_n low mid-run at q=11 -> all outputs reset with no clock edge; a forced illegal q=5 -> next q=0 and err=1.

Source files
------------

// File: rtl/seq_run_ctrl_pkg.sv
// Shared types and constants for the sequence run controller.
// Holds the FSM state encoding and the endpoints of the legal sequence.
package seq_run_ctrl_pkg;

  localparam int unsigned SEQ_W = 4;

  localparam logic [SEQ_W-1:0] SEQ_FIRST = 4'd0;
  localparam logic [SEQ_W-1:0] SEQ_LAST  = 4'd14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } run_state_e;

endpackage

// File: rtl/seq_run_ctrl_step.sv
// Next-value logic for the 0,1,3,7,9,11,13,14 cyclic sequence.
// Values outside the legal set restart the sequence and raise illegal_c.
module seq_step
  import seq_run_ctrl_pkg::*;
(
  input  logic [SEQ_W-1:0] q,
  input  logic             en,
  output logic [SEQ_W-1:0] q_next_c,
  output logic             illegal_c
);

  always_comb begin
    q_next_c  = q;
    illegal_c = 1'b0;
    if (en) begin
      case (q)
        4'd0:    q_next_c = 4'd1;
        4'd1:    q_next_c = 4'd3;
        4'd3:    q_next_c = 4'd7;
        4'd7:    q_next_c = 4'd9;
        4'd9:    q_next_c = 4'd11;
        4'd11:   q_next_c = 4'd13;
        4'd13:   q_next_c = SEQ_LAST;
        4'd14:   q_next_c = SEQ_FIRST;
        default: begin
          q_next_c  = SEQ_FIRST;
          illegal_c = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/seq_run_ctrl.sv
// Run controller: steps a fixed sequence for a requested number of passes,
// with hold/pause, abort, pass counting and a sticky illegal-value flag.
module seq_run_ctrl
  import seq_run_ctrl_pkg::*;
#(
  parameter int unsigned PASS_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              hold,
  input  logic [PASS_W-1:0] num_passes,
  output logic [SEQ_W-1:0]  q,
  output logic [PASS_W-1:0] pass_cnt,
  output logic              busy,
  output logic              wrap,
  output logic              done,
  output logic              err
);

  localparam logic [PASS_W-1:0] PASS_MAX = '1;

  run_state_e        state, state_d;
  logic [PASS_W-1:0] np_q, np_d;
  logic [SEQ_W-1:0]  q_d;
  logic [PASS_W-1:0] pass_cnt_d, pass_inc_c;
  logic              wrap_d, done_d, err_d;
  logic              step_en_c;
  logic [SEQ_W-1:0]  q_next_c;
  logic              illegal_c;

  // Only a live, un-held, un-aborted run advances the sequence.
  assign step_en_c  = (state == RUN) && !stop && !hold;
  assign pass_inc_c = (pass_cnt == PASS_MAX) ? pass_cnt : pass_cnt + PASS_W'(1);

  seq_step u_step (
    .q         (q),
    .en        (step_en_c),
    .q_next_c  (q_next_c),
    .illegal_c (illegal_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      np_q     <= '0;
      q        <= SEQ_FIRST;
      pass_cnt <= '0;
      busy     <= 1'b0;
      wrap     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_d;
      np_q     <= np_d;
      q        <= q_d;
      pass_cnt <= pass_cnt_d;
      busy     <= (state_d != IDLE);
      wrap     <= wrap_d;
      done     <= done_d;
      err      <= err_d;
    end
  end

  always_comb begin
    state_d    = state;
    np_d       = np_q;
    q_d        = q;
    pass_cnt_d = pass_cnt;
    wrap_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = err;

    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_d    = RUN;
          np_d       = num_passes;
          q_d        = SEQ_FIRST;
          pass_cnt_d = '0;
          err_d      = 1'b0;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          q_d     = SEQ_FIRST;
        end else if (hold) begin
          state_d = PAUSE;
        end else begin
          q_d   = q_next_c;
          err_d = err | illegal_c;
          if (q == SEQ_LAST) begin
            wrap_d     = 1'b1;
            pass_cnt_d = pass_inc_c;
            if ((np_q != '0) && (pass_inc_c == np_q)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
      end
      PAUSE: begin
        if (stop) begin
          state_d = IDLE;
          q_d     = SEQ_FIRST;
        end else if (!hold) begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        q_d     = SEQ_FIRST;
      end
    endcase
  end

endmodule
